// File: rtl/clk_rst_sequencer.sv
// Clock divider bank with matching clock-enables, plus a staggered reset release with soft restart.
// Optional build macro CLK_RST_SEQ_GATE_EN holds each clock channel while its reset channel is asserted.
module clk_rst_sequencer #(
    parameter int CLOCKS     = 2,
    parameter int CLOCK_BASE = 2,
    parameter int CLOCK_INC  = 1,
    parameter int RESETS     = 2,
    parameter int RESET_BASE = 16,
    parameter int RESET_INC  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              soft_rst,
    output logic [CLOCKS-1:0] clkv,
    output logic [CLOCKS-1:0] clk_ce,
    output logic [RESETS-1:0] rstv,
    output logic [RESETS-1:0] rstnv,
    output logic              busy
);

    localparam longint LP_CNT_LIMIT = (longint'(1) << CNT_WIDTH) - 1;
    localparam longint LP_H_MAX     = longint'(CLOCK_BASE) + longint'(CLOCKS - 1) * longint'(CLOCK_INC);
    localparam longint LP_R_MAX     = longint'(RESET_BASE) + longint'(RESETS - 1) * longint'(RESET_INC);
    localparam logic [CNT_WIDTH-1:0] LP_R_MAX_CNT = CNT_WIDTH'(RESET_BASE + (RESETS - 1) * RESET_INC);

    // Illegal configurations are stopped at elaboration rather than silently wrapping a counter.
    if (CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_bad_width
        $error("clk_rst_sequencer: CNT_WIDTH must be in 1..32");
    end
    if (CLOCKS < 1 || CLOCK_BASE < 1 || CLOCK_INC < 0) begin : g_bad_clock
        $error("clk_rst_sequencer: CLOCKS and CLOCK_BASE must be >= 1, CLOCK_INC >= 0");
    end
    if (RESETS < 1 || RESET_BASE < 1 || RESET_INC < 0) begin : g_bad_reset
        $error("clk_rst_sequencer: RESETS and RESET_BASE must be >= 1, RESET_INC >= 0");
    end
    if (LP_H_MAX > LP_CNT_LIMIT) begin : g_bad_half
        $error("clk_rst_sequencer: largest half-period does not fit CNT_WIDTH");
    end
    if (LP_R_MAX > LP_CNT_LIMIT) begin : g_bad_delay
        $error("clk_rst_sequencer: largest release delay does not fit CNT_WIDTH");
    end

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_COUNT,
        ST_RUN
    } state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [RESETS-1:0]     r_rstv;
    logic                  r_busy;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic [RESETS-1:0]     w_release;

    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

    // A channel is released once the count reaches its delay; the count only rises inside COUNT.
    for (genvar j = 0; j < RESETS; j++) begin : g_rel
        localparam logic [CNT_WIDTH-1:0] LP_DELAY = CNT_WIDTH'(RESET_BASE + j * RESET_INC);
        assign w_release[j] = (w_cnt_inc >= LP_DELAY);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_rstv  <= '1;
            r_busy  <= 1'b1;
        end else if (soft_rst) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
            r_rstv  <= '1;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    r_state <= ST_COUNT;
                    r_cnt   <= '0;
                    r_rstv  <= '1;
                    r_busy  <= 1'b1;
                end
                ST_COUNT: begin
                    r_cnt  <= w_cnt_inc;
                    r_rstv <= ~w_release;
                    if (w_cnt_inc == LP_R_MAX_CNT) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rstv <= '0;
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= ST_HOLD;
                    r_cnt   <= '0;
                    r_rstv  <= '1;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign rstv  = r_rstv;
    assign rstnv = ~r_rstv;
    assign busy  = r_busy;

    for (genvar i = 0; i < CLOCKS; i++) begin : g_div
        localparam logic [CNT_WIDTH-1:0] LP_HALF_M1 = CNT_WIDTH'(CLOCK_BASE + i * CLOCK_INC - 1);

        logic [CNT_WIDTH-1:0] r_div_cnt;
        logic                 r_clk;
        logic                 r_ce;
        logic                 w_wrap;
        logic                 w_hold;

        assign w_wrap = (r_div_cnt == LP_HALF_M1);

`ifdef CLK_RST_SEQ_GATE_EN
        localparam int LP_GATE = (i < RESETS) ? i : RESETS - 1;
        assign w_hold = r_rstv[LP_GATE];
`else
        assign w_hold = 1'b0;
`endif

        // The enable pulse is registered alongside the rising toggle so both appear in the same cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_div_cnt <= '0;
                r_clk     <= 1'b0;
                r_ce      <= 1'b0;
            end else if (w_hold) begin
                r_div_cnt <= '0;
                r_clk     <= 1'b0;
                r_ce      <= 1'b0;
            end else if (w_wrap) begin
                r_div_cnt <= '0;
                r_clk     <= ~r_clk;
                r_ce      <= ~r_clk;
            end else begin
                r_div_cnt <= r_div_cnt + CNT_WIDTH'(1);
                r_ce      <= 1'b0;
            end
        end

        assign clkv[i]   = r_clk;
        assign clk_ce[i] = r_ce;
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench for clk_rst_sequencer: edge-count reference model plus directed literal checks.
module tb_clk_rst_sequencer;

    localparam int CLOCKS     = 2;
    localparam int CLOCK_BASE = 2;
    localparam int CLOCK_INC  = 1;
    localparam int RESETS     = 2;
    localparam int RESET_BASE = 16;
    localparam int RESET_INC  = 4;
    localparam int CNT_WIDTH  = 16;
    localparam int R_MAX      = RESET_BASE + (RESETS - 1) * RESET_INC;

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              soft_rst = 1'b0;
    logic [CLOCKS-1:0] clkv;
    logic [CLOCKS-1:0] clk_ce;
    logic [RESETS-1:0] rstv;
    logic [RESETS-1:0] rstnv;
    logic              busy;

    int tests  = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    clk_rst_sequencer #(
        .CLOCKS    (CLOCKS),
        .CLOCK_BASE(CLOCK_BASE),
        .CLOCK_INC (CLOCK_INC),
        .RESETS    (RESETS),
        .RESET_BASE(RESET_BASE),
        .RESET_INC (RESET_INC),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .soft_rst(soft_rst),
        .clkv    (clkv),
        .clk_ce  (clk_ce),
        .rstv    (rstv),
        .rstnv   (rstnv),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: edges each divider has run, and edges since the release sequence began.
    int n_clk [CLOCKS];
    bit m_hold;
    int m_k;

    function automatic int half(input int i);
        return CLOCK_BASE + i * CLOCK_INC;
    endfunction

    function automatic logic [RESETS-1:0] exp_rstv();
        logic [RESETS-1:0] r;
        for (int j = 0; j < RESETS; j++) r[j] = m_hold || (m_k < RESET_BASE + j * RESET_INC);
        return r;
    endfunction

    function automatic logic [RESETS-1:0] exp_rstnv();
        return ~exp_rstv();
    endfunction

    function automatic logic exp_busy();
        return m_hold || (m_k < R_MAX);
    endfunction

    function automatic logic [CLOCKS-1:0] exp_clkv();
        logic [CLOCKS-1:0] c;
        for (int i = 0; i < CLOCKS; i++) c[i] = ((n_clk[i] / half(i)) % 2) == 1;
        return c;
    endfunction

    function automatic logic [CLOCKS-1:0] exp_ce();
        logic [CLOCKS-1:0] c;
        for (int i = 0; i < CLOCKS; i++) c[i] = (n_clk[i] % (2 * half(i))) == half(i);
        return c;
    endfunction

`ifdef CLK_RST_SEQ_GATE_EN
    logic [RESETS-1:0] m_pre_rstv;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = 1'b1;
            m_k    = 0;
            for (int i = 0; i < CLOCKS; i++) n_clk[i] = 0;
        end else begin
`ifdef CLK_RST_SEQ_GATE_EN
            m_pre_rstv = exp_rstv();
            for (int i = 0; i < CLOCKS; i++) begin
                if (m_pre_rstv[(i < RESETS) ? i : RESETS - 1]) n_clk[i] = 0;
                else n_clk[i] = n_clk[i] + 1;
            end
`else
            for (int i = 0; i < CLOCKS; i++) n_clk[i] = n_clk[i] + 1;
`endif
            if (soft_rst) m_hold = 1'b1;
            else if (m_hold) begin
                m_hold = 1'b0;
                m_k    = 0;
            end else if (m_k < R_MAX) m_k = m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("clkv", 32'(clkv), 32'(exp_clkv()));
            check("clk_ce", 32'(clk_ce), 32'(exp_ce()));
            check("rstv", 32'(rstv), 32'(exp_rstv()));
            check("rstnv", 32'(rstnv), 32'(exp_rstnv()));
            check("busy", 32'(busy), 32'(exp_busy()));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_clkv", 32'(clkv), 32'h0);
        check("arst_ce", 32'(clk_ce), 32'h0);
        check("arst_rstv", 32'(rstv), 32'h3);
        check("arst_rstnv", 32'(rstnv), 32'h0);
        check("arst_busy", 32'(busy), 32'h1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        soft_rst = 1'b0;
        edges(3);
        chk_en = 1'b1;
        check("por_rstv", 32'(rstv), 32'h3);
        check("por_rstnv", 32'(rstnv), 32'h0);
        check("por_busy", 32'(busy), 32'h1);
        check("por_clkv", 32'(clkv), 32'h0);

        // Power-on release: COUNT entered on edge 1, channels release on edges 17 and 21.
        rst = 1'b0;
        edges(1);
        check("e1_rstv", 32'(rstv), 32'h3);
`ifndef CLK_RST_SEQ_GATE_EN
        check("e1_clkv", 32'(clkv), 32'h0);
        edges(1);
        check("e2_clkv", 32'(clkv), 32'h1);
        check("e2_ce", 32'(clk_ce), 32'h1);
        edges(1);
        check("e3_clkv", 32'(clkv), 32'h3);
        check("e3_ce", 32'(clk_ce), 32'h2);
        edges(13);
`else
        edges(15);
`endif
        check("e16_rstv", 32'(rstv), 32'h3);
        edges(1);
        check("e17_rstv", 32'(rstv), 32'h2);
        check("e17_rstnv", 32'(rstnv), 32'h1);
        check("e17_busy", 32'(busy), 32'h1);
        edges(4);
        check("e21_rstv", 32'(rstv), 32'h0);
        check("e21_busy", 32'(busy), 32'h0);
`ifdef CLK_RST_SEQ_GATE_EN
        check("gate_e21_clkv1", 32'(clkv[1]), 32'h0);
        edges(2);
        check("gate_e23_ce1", 32'(clk_ce[1]), 32'h0);
        edges(1);
        check("gate_e24_ce1", 32'(clk_ce[1]), 32'h1);
`else
        edges(3);
`endif

        // Soft reset from RUN, then again at COUNT cycle 10.
        soft_rst = 1'b1;
        edges(1);
        check("srun_rstv", 32'(rstv), 32'h3);
        check("srun_busy", 32'(busy), 32'h1);
        soft_rst = 1'b0;
        edges(11);
        soft_rst = 1'b1;
        edges(1);
        check("scnt_rstv", 32'(rstv), 32'h3);
        check("scnt_busy", 32'(busy), 32'h1);

        // Soft reset on the edge where the count would reach the first release delay.
        soft_rst = 1'b0;
        edges(16);
        check("pre16_rstv", 32'(rstv), 32'h3);
        soft_rst = 1'b1;
        edges(1);
        check("clash_rstv", 32'(rstv), 32'h3);
        check("clash_busy", 32'(busy), 32'h1);
        soft_rst = 1'b0;
        edges(17);
        check("rerun17_rstv", 32'(rstv), 32'h2);
        edges(4);
        check("rerun21_rstv", 32'(rstv), 32'h0);

        // Asynchronous reset between edges in the middle of COUNT, then a full sequence.
        soft_rst = 1'b1;
        edges(1);
        soft_rst = 1'b0;
        edges(6);
        async_reset_pulse();
        edges(17);
        check("post_arst17_rstv", 32'(rstv), 32'h2);
        edges(4);
        check("post_arst21_rstv", 32'(rstv), 32'h0);
        check("post_arst21_busy", 32'(busy), 32'h0);

        // Randomized soft resets and occasional asynchronous resets, checked every cycle by the model.
        for (int it = 0; it < 3000; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                soft_rst = 1'b1;
                edges($urandom_range(1, 3));
                soft_rst = 1'b0;
            end else if (r < 3) begin
                async_reset_pulse();
            end else begin
                soft_rst = 1'b0;
                edges(1);
            end
        end

        soft_rst = 1'b0;
        edges(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
Synthesizable, parametrised successor to the simulation-only clock/reset stimulus block. From one system clock it derives CLOCKS divided clocks with matching clock-enable pulses. It also releases RESETS reset channels in a staggered order, with a soft-reset request that re-runs the sequence. It sits at the top of a subsystem and feeds both the testbenches and the FPGA builds.

Parameters:
- CLOCKS, 2, number of divided clock channels (>=1)
- CLOCK_BASE, 2, half-period of channel 0 in clk cycles (>=1)
- CLOCK_INC, 1, half-period increment per additional clock channel
- RESETS, 2, number of reset channels (>=1)
- RESET_BASE, 16, release delay of reset channel 0 in clk cycles (>=1)
- RESET_INC, 4, release delay increment per additional reset channel
- CNT_WIDTH, 16, width of all internal counters; every half-period and release delay must fit

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- soft_rst  in  1  synchronous request to restart the reset sequence
- clkv  out  CLOCKS  divided clocks, registered
- clk_ce  out  CLOCKS  one-cycle pulse per rising edge of the matching clkv bit
- rstv  out  RESETS  active-high resets
- rstnv  out  RESETS  active-low resets, always ~rstv
- busy  out  1  high until every reset channel is released

Behaviour:
- Reset values (rst high, applied immediately and asynchronously): clkv=0, clk_ce=0, rstv=all 1, rstnv=all 0, busy=1, FSM=HOLD, all counters 0.
- Half-period of clock channel i: H_i = CLOCK_BASE + i*CLOCK_INC.
  - Per-channel counter counts 0..H_i-1 and wraps to 0.
  - On the wrap, clkv[i] toggles.
  - clk_ce[i] is registered and high for exactly the one cycle in which clkv[i] first reads 1.
  - Result: clkv[i] period is 2*H_i clk cycles, 50% duty.
  - Dividers are free-running; only rst stops them. soft_rst does not affect them.
- Release delay of reset channel j: R_j = RESET_BASE + j*RESET_INC. R_max = R_(RESETS-1).
- FSM states:
  - HOLD: cnt=0, rstv=all 1, busy=1. Go to COUNT on the first edge where soft_rst=0.
  - COUNT: cnt increments each edge. rstv[j] clears on the edge where cnt becomes R_j, i.e. R_j edges after entering COUNT. When cnt reaches R_max, go to RUN; on that same edge busy clears together with the last rstv bit.
  - RUN: rstv=all 0, busy=0, cnt holds.
- soft_rst=1 in any state: on the next edge go to HOLD, all rstv re-assert, busy=1, cnt=0. While soft_rst stays high, remain in HOLD.
- Simultaneous soft_rst and a release edge: soft_rst wins and no channel releases.
- RESET_INC=0: all channels release on the same edge.
- Released resets never re-assert except through rst or soft_rst.
- CLOCK_BASE=1 with CLOCK_INC=0: every channel runs at clk/2 and clk_ce is high every other cycle.
- Counters never wrap. Parameter values that would overflow CNT_WIDTH are illegal and must be rejected at elaboration with $error.

Optional Feature:
- Macro: CLK_RST_SEQ_GATE_EN.
- Defined: clock channel i is gated by rstv[k], where k = min(i, RESETS-1).
  - While rstv[k]=1, the channel counter is held at 0, clkv[i]=0 and clk_ce[i]=0.
  - After rstv[k] falls, the first clkv[i] rising edge and clk_ce pulse come exactly H_i cycles later.
- Undefined: dividers are free-running as described in Behaviour.

Test Plan:
- Default parameters, rst released → clkv[0] has period 4 (high 2 / low 2) and clkv[1] has period 6; clk_ce[0] pulses every 4 cycles and clk_ce[1] every 6, each aligned to the first high cycle of its clkv bit.
- rst released, soft_rst=0 → rstv[0] falls 16 edges and rstv[1] 20 edges after COUNT entry; busy falls with rstv[1]; rstnv==~rstv at every cycle.
- 1-cycle soft_rst pulse at COUNT cycle 10, and again in RUN → on the next edge rstv=2'b11 and busy=1; the release sequence repeats with the full 16/20 delays; clkv phase is undisturbed.
- soft_rst asserted on the same edge where cnt would reach 16 → rstv[0] stays 1, FSM enters HOLD.
- rst asserted mid-COUNT between clock edges → all outputs take their reset values before the next edge; after rst drops, the full sequence runs.
- CLK_RST_SEQ_GATE_EN defined → clkv[1] stays 0 until rstv[1] falls; first clk_ce[1] arrives exactly 3 cycles after that fall.
